// File: rtl/comp_seq_pkg.sv
// Shared types for the bit-serial magnitude comparator: FSM states and k/l result codes.
// No logic; no latency.
// No flow control; constants only.
package comp_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] KL_EQ = 2'b00;
    localparam logic [1:0] KL_GT = 2'b10;
    localparam logic [1:0] KL_LT = 2'b01;

endpackage

// File: rtl/comp_cell.sv
// One-bit magnitude extender: passes a decided k/l through, otherwise decides on bits a/b.
// Latency: purely combinational.
// Backpressure: none.
module comp_cell
    import comp_seq_pkg::*;
(
    input  logic ki,
    input  logic li,
    input  logic a,
    input  logic b,
    output logic ko,
    output logic lo
);

    always_comb begin
        {ko, lo} = KL_EQ;
        if (ki | li) begin
            {ko, lo} = {ki, li};
        end else if (a & ~b) begin
            {ko, lo} = KL_GT;
        end else if (~a & b) begin
            {ko, lo} = KL_LT;
        end
    end

endmodule

// File: rtl/comp_seq_ctrl.sv
// Bit-serial X/Y magnitude comparator, MSB first, one comp_cell reused each cycle.
// Latency: WIDTH cycles from acceptance; with COMP_SEQ_EARLY_EXIT_EN, 1 + leading equal bits.
// Backpressure: start is taken only in IDLE; start while busy is ignored, not queued.
module comp_seq_ctrl
    import comp_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic             k,
    output logic             l
);

    localparam int IW = $clog2(WIDTH);

    state_t          state;
    state_t          state_nxt;
    logic [WIDTH-1:0] xr;
    logic [WIDTH-1:0] yr;
    logic [IW-1:0]   idx;
    logic            ka;
    logic            la;
    logic            ko;
    logic            lo;
    logic            accept;
    logic            last;

    comp_cell u_cell (
        .ki (ka),
        .li (la),
        .a  (xr[idx]),
        .b  (yr[idx]),
        .ko (ko),
        .lo (lo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // Exit is decided at idx=0 before decrementing, so idx never wraps.
`ifdef COMP_SEQ_EARLY_EXIT_EN
                last = (idx == '0) | ko | lo;
`else
                last = (idx == '0);
`endif
                if (last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            xr       <= '0;
            yr       <= '0;
            idx      <= '0;
            {ka, la} <= KL_EQ;
            {k, l}   <= KL_EQ;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                xr       <= x;
                yr       <= y;
                idx      <= IW'(WIDTH - 1);
                {ka, la} <= KL_EQ;
            end else if (state == RUN) begin
                {ka, la} <= {ko, lo};
                if (last) begin
                    {k, l} <= {ko, lo};
                    done   <= 1'b1;
                end else begin
                    idx <= idx - IW'(1);
                end
            end
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_comp_seq_ctrl.sv
// Directed self-checking bench for comp_seq_ctrl (WIDTH=8); honours COMP_SEQ_EARLY_EXIT_EN.
module tb_comp_seq_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic             k;
    logic             l;

    int checks = 0;
    int errors = 0;

`ifdef COMP_SEQ_EARLY_EXIT_EN
    localparam int LAT_80_7F = 1;
    localparam int LAT_05_03 = 6;
`else
    localparam int LAT_80_7F = WIDTH;
    localparam int LAT_05_03 = WIDTH;
`endif

    comp_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .x     (x),
        .y     (y),
        .busy  (busy),
        .done  (done),
        .k     (k),
        .l     (l)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called right after the accepting edge; returns in the done cycle.
    task automatic wait_result(input string tag, input logic [1:0] exp_kl,
                               input int exp_lat, input logic [1:0] kl_during);
        int cnt      = 0;
        int busy_bad = 0;
        int kl_bad   = 0;
        while (!done && cnt < 40) begin
            step();
            cnt++;
            if (!done) begin
                if (busy !== 1'b1) busy_bad++;
                if ({k, l} !== kl_during) kl_bad++;
            end
        end
        check({tag, "_latency"}, cnt, exp_lat);
        check({tag, "_kl"}, {30'd0, k, l}, {30'd0, exp_kl});
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_busy_during"}, busy_bad, 0);
        check({tag, "_kl_held"}, kl_bad, 0);
    endtask

    initial begin
        int done_seen;
        reset = 1'b1;
        start = 1'b0;
        x     = '0;
        y     = '0;
        step();
        step();
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_busy", {31'd0, busy}, 32'd0);
            check("idle_done", {31'd0, done}, 32'd0);
            check("idle_kl", {30'd0, k, l}, 32'd0);
        end

        // Equal operands always run the full width.
        x = 8'hA5; y = 8'hA5; start = 1'b1;
        step();
        start = 1'b0;
        check("eq_busy_after_accept", {31'd0, busy}, 32'd1);
        wait_result("eq", 2'b00, WIDTH, 2'b00);
        step();
        check("eq_done_pulse_1cyc", {31'd0, done}, 32'd0);

        x = 8'h80; y = 8'h7F; start = 1'b1;
        step();
        start = 1'b0;
        wait_result("gt_msb", 2'b10, LAT_80_7F, 2'b00);
        step();
        check("gt_done_pulse_1cyc", {31'd0, done}, 32'd0);

        // start held through the run with operands changed mid-run.
        x = 8'h12; y = 8'h13; start = 1'b1;
        step();
        x = 8'hFF; y = 8'h00;
        wait_result("lt_hold", 2'b01, WIDTH, 2'b10);
        start = 1'b0;
        step();
        check("lt_hold_no_second", {31'd0, busy}, 32'd0);
        check("lt_hold_done_low", {31'd0, done}, 32'd0);

        // Back-to-back: second start lands in the done cycle.
        x = 8'h05; y = 8'h03; start = 1'b1;
        step();
        start = 1'b0;
        wait_result("b2b_first", 2'b10, LAT_05_03, 2'b01);
        x = 8'h03; y = 8'h05; start = 1'b1;
        step();
        start = 1'b0;
        check("b2b_second_busy", {31'd0, busy}, 32'd1);
        wait_result("b2b_second", 2'b01, LAT_05_03, 2'b10);
        step();

        // Abort mid-run with reset.
        x = 8'h12; y = 8'h13; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_kl", {30'd0, k, l}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done || busy) done_seen++;
        end
        check("abort_no_done", done_seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
